// File: rtl/candy_mem_resp_pkg.sv
// candy_mem_resp_pkg: shared widths, reset level, FSM encoding and helpers for the memory responder.
// Build option: define CANDY_MEM_RANGE_CHK_EN to enable out-of-range detection in candy_mem_resp/candy_mem_array.
// Consumers import with: import candy_mem_resp_pkg::*;
package candy_mem_resp_pkg;

   // Default geometry of the word storage seen by the core.
   localparam int SRAM_ADDR_W = 8;
   localparam int SRAM_DATA_W = 32;

   // Level of rst that resets the block.
   localparam logic RST_ENABLE = 1'b1;

   // Latency counter width: enough for the largest supported read latency (15).
   localparam int CNT_W      = 4;
   localparam int RD_LAT_MAX = 15;

   // Responder FSM encoding.
   typedef enum logic [1:0] {
      MEM_IDLE = 2'b00,
      MEM_WAIT = 2'b01,
      MEM_RESP = 2'b10
   } mem_state_e;

   // True when a word address falls inside the populated storage.
   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
      return addr < depth;
   endfunction

   // Index width for a storage of the given depth (never narrower than one bit).
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/candy_mem_array.sv
// candy_mem_array: DEPTH x DATA_W word storage, one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge; read data follows raddr_i combinationally (pre-write value).
// No backpressure. CANDY_MEM_RANGE_CHK_EN: writes at or beyond DEPTH are dropped instead of wrapping.
module candy_mem_array
   import candy_mem_resp_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W,
   parameter int DEPTH  = 256
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int IDX_W = idx_width(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  widx;
   logic [IDX_W-1:0]  ridx;
   logic              wr_ok;

   // Map word addresses onto storage rows and decide whether the write may land.
   // Taking the address modulo DEPTH gives wrap-around for power-of-two depths and
   // is the identity for any in-range address when range checking is enabled.
   always_comb begin
      widx = IDX_W'(32'(waddr_i) % 32'(DEPTH));
      ridx = IDX_W'(32'(raddr_i) % 32'(DEPTH));
`ifdef CANDY_MEM_RANGE_CHK_EN
      wr_ok = we_i && addr_in_range(32'(waddr_i), 32'(DEPTH));
`else
      wr_ok = we_i;
`endif
   end

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         mem_q[widx] <= wdata_i;
      end
   end

   // Combinational read of the current (pre-write) contents.
   always_comb begin
      rdata_o = mem_q[ridx];
   end

endmodule

// File: rtl/candy_mem_resp.sv
// candy_mem_resp: read responder with RD_LAT-cycle latency, busy flag and an always-accepted write port.
// Latency: request accepted at edge N -> rdata_ready pulses after edge N+RD_LAT-1 (RD_LAT legal 1..15).
// No stall: requests outside IDLE are ignored (one read per RD_LAT+1 cycles); writes never wait. Option: CANDY_MEM_RANGE_CHK_EN.
module candy_mem_resp
   import candy_mem_resp_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_ready,
   output logic              busy,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_err
);

   // WAIT holds for RD_LAT-1 cycles: the counter starts at RD_LAT-2 and RESP is
   // entered on the edge where it reads zero. RD_LAT=1 skips WAIT entirely.
   localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rdy_q,   rdy_d;
   logic              busy_q,  busy_d;
   logic              err_q,   err_d;

   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] arr_rdata;
   logic              fwd_hit;
   logic              oob;
   logic [DATA_W-1:0] cap_data;

   candy_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk_i   (clk),
      .we_i    (write_enable),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (cap_addr),
      .rdata_o (arr_rdata)
   );

   // State and output registers; reset drops any in-flight read.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      unique case (state_q)
         MEM_IDLE: begin
            if (read_enable) begin
               addr_d = raddr;
               if (RD_LAT == 1) begin
                  state_d = MEM_RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            if (cnt_q == '0) begin
               state_d = MEM_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         MEM_RESP: begin
            state_d = MEM_IDLE;
         end
         default: begin
            state_d = MEM_IDLE;
         end
      endcase
   end

   // Capture datapath. With RD_LAT=1 the capture edge is also the accepting edge,
   // so the address comes straight from raddr rather than addr_q. A write to the
   // same address on the capture edge is forwarded so the read sees the new word.
   always_comb begin
      cap_addr = (state_q == MEM_IDLE) ? raddr : addr_q;
      fwd_hit  = write_enable && (waddr == cap_addr);
`ifdef CANDY_MEM_RANGE_CHK_EN
      oob = !addr_in_range(32'(cap_addr), 32'(DEPTH));
`else
      oob = 1'b0;
`endif
      if (oob) begin
         cap_data = '0;
      end else if (fwd_hit) begin
         cap_data = wdata;
      end else begin
         cap_data = arr_rdata;
      end
   end

   // Output decode: load rdata only when entering RESP, hold it otherwise;
   // ready/busy/err are registered decodes of the next state.
   always_comb begin
      rdata_d = rdata_q;
      rdy_d   = (state_d == MEM_RESP);
      busy_d  = (state_d != MEM_IDLE);
      err_d   = 1'b0;
      if (state_d == MEM_RESP) begin
         rdata_d = cap_data;
         err_d   = oob;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_ready = rdy_q;
   assign busy        = busy_q;
   assign mem_err     = err_q;

endmodule

// File: tb/tb_candy_mem_resp.sv
// tb_candy_mem_resp: three responders (RD_LAT 2, 1, 4) share one stimulus stream and are checked every cycle
// against a transaction-level model (response edge = accept edge + RD_LAT - 1, next accept = accept + RD_LAT + 1).
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_candy_mem_resp;

`ifdef CANDY_MEM_RANGE_CHK_EN
   localparam int DEP = 200;
`else
   localparam int DEP = 128;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read_enable = 1'b0;
   logic [7:0]  raddr = '0;
   logic        write_enable = 1'b0;
   logic [7:0]  waddr = '0;
   logic [31:0] wdata = '0;

   logic [31:0] rdata_w [3];
   logic        rdy_w   [3];
   logic        busy_w  [3];
   logic        err_w   [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   candy_mem_resp #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEP), .RD_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .read_enable(read_enable), .raddr(raddr),
      .rdata(rdata_w[0]), .rdata_ready(rdy_w[0]), .busy(busy_w[0]),
      .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .mem_err(err_w[0]));

   candy_mem_resp #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEP), .RD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .read_enable(read_enable), .raddr(raddr),
      .rdata(rdata_w[1]), .rdata_ready(rdy_w[1]), .busy(busy_w[1]),
      .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .mem_err(err_w[1]));

   candy_mem_resp #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEP), .RD_LAT(4)) u_lat4 (
      .clk(clk), .rst(rst), .read_enable(read_enable), .raddr(raddr),
      .rdata(rdata_w[2]), .rdata_ready(rdy_w[2]), .busy(busy_w[2]),
      .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .mem_err(err_w[2]));

   // Reference model state
   int          lat_tab [3] = '{2, 1, 4};
   int          e = 0;
   int          resp_e   [3] = '{-1, -1, -1};
   int          next_acc [3] = '{0, 0, 0};
   int          m_addr   [3];
   logic [31:0] m_data   [3] = '{0, 0, 0};
   logic        m_rdy    [3] = '{0, 0, 0};
   logic        m_busy   [3] = '{0, 0, 0};
   logic        m_err    [3] = '{0, 0, 0};
   logic [31:0] mmem     [256];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_inrng(input int a);
`ifdef CANDY_MEM_RANGE_CHK_EN
      return a < DEP;
`else
      return 1'b1;
`endif
   endfunction

   function automatic int m_idx(input int a);
      return a % DEP;
   endfunction

   // One clock edge: advance the model with the inputs seen at the edge, then compare all DUTs.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            resp_e[i]   = -1;
            next_acc[i] = e + 1;
            m_data[i]   = '0;
            m_rdy[i]    = 1'b0;
            m_busy[i]   = 1'b0;
            m_err[i]    = 1'b0;
         end else begin
            if (e >= next_acc[i] && read_enable) begin
               m_addr[i]   = int'(raddr);
               resp_e[i]   = e + lat_tab[i] - 1;
               next_acc[i] = e + lat_tab[i] + 1;
            end
            m_rdy[i] = (e == resp_e[i]);
            m_err[i] = 1'b0;
            if (m_rdy[i]) begin
               if (!m_inrng(m_addr[i])) begin
                  m_data[i] = '0;
                  m_err[i]  = 1'b1;
               end else if (write_enable && int'(waddr) == m_addr[i]) begin
                  m_data[i] = wdata;
               end else begin
                  m_data[i] = mmem[m_idx(m_addr[i])];
               end
            end
            m_busy[i] = (e <= resp_e[i]);
         end
      end
      if (write_enable && m_inrng(int'(waddr))) mmem[m_idx(int'(waddr))] = wdata;
      e++;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rdy_l%0d", lat_tab[i]),   32'(rdy_w[i]),  32'(m_rdy[i]));
         check($sformatf("busy_l%0d", lat_tab[i]),  32'(busy_w[i]), 32'(m_busy[i]));
         check($sformatf("rdata_l%0d", lat_tab[i]), rdata_w[i],     m_data[i]);
         check($sformatf("err_l%0d", lat_tab[i]),   32'(err_w[i]),  32'(m_err[i]));
      end
   endtask

   task automatic idle_inputs();
      read_enable  = 1'b0;
      write_enable = 1'b0;
   endtask

   task automatic drain(input int n);
      idle_inputs();
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      write_enable = 1'b1; waddr = a; wdata = d; read_enable = 1'b0;
      tick();
      write_enable = 1'b0;
   endtask

   int first [3];
   int pulses[3];

   initial begin
      // Reset: all outputs low/zero
      rst = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      check("rst_rdy", 32'(rdy_w[0]), 32'd0);
      check("rst_busy", 32'(busy_w[0]), 32'd0);
      check("rst_rdata", rdata_w[0], 32'd0);
      check("rst_err", 32'(err_w[0]), 32'd0);
      rst = 1'b0;
      drain(2);

      // Preload every storage row
      for (int a = 0; a < 256; a++) wr(8'(a), $urandom);
      drain(2);

      // Basic read, RD_LAT=2 timing
      wr(8'h10, 32'hDEADBEEF);
      read_enable = 1'b1; raddr = 8'h10;
      tick();
      read_enable = 1'b0;
      check("t1_busyA", 32'(busy_w[0]), 32'd1);
      check("t1_rdyA", 32'(rdy_w[0]), 32'd0);
      tick();
      check("t1_rdyB", 32'(rdy_w[0]), 32'd1);
      check("t1_busyB", 32'(busy_w[0]), 32'd1);
      check("t1_data", rdata_w[0], 32'hDEADBEEF);
      tick();
      check("t1_rdyC", 32'(rdy_w[0]), 32'd0);
      check("t1_busyC", 32'(busy_w[0]), 32'd0);
      check("t1_hold", rdata_w[0], 32'hDEADBEEF);
      drain(6);

      // Latency per instance: first pulse offset after the accepting edge
      wr(8'h05, 32'h12345678);
      for (int i = 0; i < 3; i++) begin first[i] = -1; pulses[i] = 0; end
      read_enable = 1'b1; raddr = 8'h05;
      for (int k = 0; k < 8; k++) begin
         tick();
         read_enable = 1'b0;
         for (int i = 0; i < 3; i++) if (rdy_w[i]) begin
            pulses[i]++;
            if (first[i] < 0) first[i] = k;
         end
      end
      check("lat2_off", 32'(first[0]), 32'd1);
      check("lat1_off", 32'(first[1]), 32'd0);
      check("lat4_off", 32'(first[2]), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("lat%0d_pulses", lat_tab[i]), 32'(pulses[i]), 32'd1);
         check($sformatf("lat%0d_data", lat_tab[i]), rdata_w[i], 32'h12345678);
      end
      drain(6);

      // read_enable held for 12 cycles: one response per RD_LAT+1 cycles
      for (int i = 0; i < 3; i++) pulses[i] = 0;
      read_enable = 1'b1; raddr = 8'h05;
      for (int k = 0; k < 12; k++) begin
         tick();
         for (int i = 0; i < 3; i++) if (rdy_w[i]) pulses[i]++;
      end
      check("hold_l2", 32'(pulses[0]), 32'd4);
      check("hold_l1", 32'(pulses[1]), 32'd6);
      check("hold_l4", 32'(pulses[2]), 32'd2);
      drain(8);

      // Write-first forwarding on the capture edge
      wr(8'h20, 32'h1);
      read_enable = 1'b1; raddr = 8'h20;
      tick();
      read_enable = 1'b0;
      write_enable = 1'b1; waddr = 8'h20; wdata = 32'h2;
      tick();
      write_enable = 1'b0;
      check("fwd_hit", rdata_w[0], 32'h2);
      drain(6);
      // Same write one cycle after the response: old value returned
      wr(8'h20, 32'h1);
      read_enable = 1'b1; raddr = 8'h20;
      tick();
      read_enable = 1'b0;
      tick();
      check("fwd_late_rdy", 32'(rdy_w[0]), 32'd1);
      write_enable = 1'b1; waddr = 8'h20; wdata = 32'h2;
      tick();
      write_enable = 1'b0;
      check("fwd_late", rdata_w[0], 32'h1);
      drain(6);

      // Reset while a read is pending
      read_enable = 1'b1; raddr = 8'h10;
      tick();
      read_enable = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("midrst_rdy%0d", lat_tab[i]), 32'(rdy_w[i]), 32'd0);
         check($sformatf("midrst_busy%0d", lat_tab[i]), 32'(busy_w[i]), 32'd0);
         check($sformatf("midrst_rdata%0d", lat_tab[i]), rdata_w[i], 32'd0);
      end
      drain(4);
      read_enable = 1'b1; raddr = 8'h10;
      tick();
      read_enable = 1'b0;
      tick();
      check("postrst_rdy", 32'(rdy_w[0]), 32'd1);
      check("postrst_data", rdata_w[0], 32'hDEADBEEF);
      drain(6);

`ifdef CANDY_MEM_RANGE_CHK_EN
      // Out-of-range read returns zero with mem_err
      read_enable = 1'b1; raddr = 8'hC8;
      tick();
      read_enable = 1'b0;
      tick();
      check("oob_data", rdata_w[0], 32'd0);
      check("oob_err", 32'(err_w[0]), 32'd1);
      tick();
      check("oob_err_clr", 32'(err_w[0]), 32'd0);
`else
      // Address wrap modulo DEPTH
      wr(8'h81, 32'h55);
      read_enable = 1'b1; raddr = 8'h01;
      tick();
      read_enable = 1'b0;
      tick();
      check("wrap_data", rdata_w[0], 32'h55);
      check("wrap_err", 32'(err_w[0]), 32'd0);
`endif
      drain(6);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst          = ($urandom_range(0, 99) == 0);
         read_enable  = ($urandom_range(0, 2) != 0);
         raddr        = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
         write_enable = ($urandom_range(0, 1) != 0);
         waddr        = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
         wdata        = $urandom;
         tick();
      end
      rst = 1'b0;
      drain(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/candy_mem_resp.md
Name: candy_mem_resp

Overview:
- Memory responder for the fetch/load read handshake: read_enable/raddr in, rdata/rdata_ready out.
- Adds a configurable read latency, a busy indication and a single-cycle write port driven by the writeback stage.
- Sits between the core's IF/WB stages and the word storage.
- Models a real multi-cycle SRAM so that the core control FSM is exercised against non-zero memory latency.

Parameters:
- ADDR_W, 8, address width in bits (matches `SRAMAddrWidth).
- DATA_W, 32, data width in bits (matches `SRAMDataWidth).
- DEPTH, 256, number of words; must be a power of two unless range checking is compiled in.
- RD_LAT, 2, cycles from request acceptance to rdata_ready assertion; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable).
- read_enable  in  1  read request; sampled only in IDLE.
- raddr  in  ADDR_W  read word address; sampled with read_enable.
- rdata  out  DATA_W  read data, registered; stable until next response.
- rdata_ready  out  1  one-cycle pulse: rdata valid for the accepted request.
- busy  out  1  high while a read is in flight (state != IDLE).
- write_enable  in  1  write strobe; accepted in any state.
- waddr  in  ADDR_W  write word address.
- wdata  in  DATA_W  write data.
- mem_err  out  1  out-of-range flag, valid with rdata_ready (optional feature; tied 0 otherwise).

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, cnt=0, addr_q=0, rdata=0, rdata_ready=0, busy=0, mem_err=0.
  - Storage contents are not cleared.
  - Reset mid-read drops the pending request; no rdata_ready is produced for it.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, read_enable=1: latch addr_q<=raddr. If RD_LAT=1, go to RESP; else cnt<=RD_LAT-2 and go to WAIT.
  - IDLE, read_enable=0: stay in IDLE.
  - WAIT: if cnt==0 go to RESP, else cnt<=cnt-1.
  - RESP: rdata_ready=1 for exactly one cycle, then go to IDLE unconditionally.
  - read_enable is ignored outside IDLE; a new request needs read_enable high in a later IDLE cycle.
- Latency: request sampled at edge N gives rdata_ready high during cycle N+RD_LAT.
- Throughput: at most one read per RD_LAT+1 cycles.
- rdata capture happens on the edge that enters RESP:
  - rdata <= mem[addr_q], with write-first forwarding.
  - If write_enable=1 and waddr==addr_q in the cycle before that edge, rdata<=wdata.
  - Writes committed earlier are always visible.
- Writes:
  - mem[waddr]<=wdata on any edge with write_enable=1, independent of FSM state.
  - A write never stalls or delays a read.
- rdata holds its value after rdata_ready falls and is not cleared between reads.
- busy is a registered decode of state: 1 in WAIT and RESP, 0 in IDLE.
- Address indexing without the optional feature: index = addr mod DEPTH (low log2(DEPTH) bits).

Optional Feature:
- Macro: CANDY_MEM_RANGE_CHK_EN.
- Defined:
  - Any read with addr_q>=DEPTH returns rdata=0, with mem_err=1 for the same cycle as rdata_ready.
  - Writes with waddr>=DEPTH are dropped.
  - DEPTH need not be a power of two.
- Undefined:
  - Addresses wrap modulo DEPTH, as in the indexing rule above.
  - mem_err is tied to 0.

Decomposition:
- candy_defines.v holds `SRAMAddrWidth, `SRAMDataWidth, `RstEnable and the state encodings `MemIdle=2'b00, `MemWait=2'b01, `MemResp=2'b10.
- One sub-module, candy_mem_array: DEPTH x DATA_W storage with one synchronous write port and one combinational read port.
- candy_mem_resp instantiates candy_mem_array and contains the FSM, counter and forwarding mux.

Test Plan:
- Reset then idle, RD_LAT=2: all outputs 0. Write 0xDEADBEEF to 0x10, then read 0x10 -> rdata_ready pulses exactly 2 cycles after the request edge, rdata=0xDEADBEEF, busy high for 2 cycles.
- RD_LAT=1, then RD_LAT=4, reading addr 0x05 preloaded with 0x12345678 -> rdata_ready at cycle +1 and cycle +4 respectively, each a single-cycle pulse.
- read_enable held high continuously for 12 cycles with RD_LAT=2 -> exactly 4 responses, one every 3 cycles; requests during busy are ignored.
- Read 0x20 (old value 0x1) with a write of 0x2 to 0x20 in the cycle before RESP -> rdata=0x2. The same write one cycle after rdata_ready -> that response returns 0x1.
- Assert rst in WAIT -> no rdata_ready, busy=0 next cycle, rdata=0; a following read operates normally.
- CANDY_MEM_RANGE_CHK_EN with DEPTH=200: read 0xC8 -> rdata=0, mem_err=1. Without the macro and DEPTH=128: write 0x55 to 0x81, read 0x01 -> 0x55.
